// File: rtl/utype_pkg.sv
// Shared encodings and constants for the pipelined U-type execution unit.
package utype_pkg;

    typedef enum logic [1:0] {
        OP_LUI     = 2'b00,
        OP_AUIPC   = 2'b01,
        OP_LINK    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    localparam int unsigned LINK_OFFSET  = 4;
    localparam int unsigned IMM_LOW_BITS = 12;

endpackage

// File: rtl/utype_pipe_slice.sv
// One valid/ready register slice; the enclosing pipeline supplies the advance
// condition so the ready chain is computed in a single place.
module utype_pipe_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         advance,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (advance) begin
                valid_q <= in_valid;
            end
            // Payload only moves on a real transfer so a stalled entry stays stable.
            if (advance && in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/utype_exec_pipe.sv
// Pipelined LUI / AUIPC / link-address unit with valid/ready flow control,
// flush and a destination tag carried alongside each result.
module utype_exec_pipe
    import utype_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAGW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [TAGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_rd,
    output logic            out_illegal
);

    localparam int unsigned PW = XLEN + TAGW + 1;
    localparam logic [XLEN-1:0] IMM_MASK =
        {{(XLEN - IMM_LOW_BITS){1'b1}}, {IMM_LOW_BITS{1'b0}}};
    localparam logic [XLEN-1:0] LINK_ADD = XLEN'(LINK_OFFSET);

    logic [XLEN-1:0] imm_eff;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic [PW-1:0]   payload_in;

    logic [STAGES-1:0] slice_valid;
    logic [STAGES-1:0] stage_ready;
    logic [PW-1:0]     slice_data [STAGES];

    assign imm_eff = in_imm & IMM_MASK;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        unique case (op_e'(in_op))
            OP_LUI:     result  = imm_eff;
            OP_AUIPC:   result  = in_pc + imm_eff;
            OP_LINK:    result  = in_pc + LINK_ADD;
            OP_ILLEGAL: illegal = 1'b1;
        endcase
    end

    assign payload_in = {result, in_rd, illegal};

    // Ready ripples back from out_ready: a slice may load if it is empty or
    // everything downstream of it will move this cycle.
    always_comb begin : p_ready
        logic rdy;
        stage_ready = '0;
        rdy         = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            rdy            = !slice_valid[k] | rdy;
            stage_ready[k] = rdy;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          up_valid;
        logic [PW-1:0] up_data;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = payload_in;
        end else begin : g_next
            assign up_valid = slice_valid[k-1];
            assign up_data  = slice_data[k-1];
        end

        utype_pipe_slice #(
            .W(PW)
        ) u_slice (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .advance  (stage_ready[k]),
            .in_valid (up_valid),
            .in_data  (up_data),
            .out_valid(slice_valid[k]),
            .out_data (slice_data[k])
        );
    end

    assign in_ready    = stage_ready[0];
    assign out_valid   = slice_valid[STAGES-1];
    assign out_result  = slice_data[STAGES-1][PW-1 -: XLEN];
    assign out_rd      = slice_data[STAGES-1][TAGW:1];
    assign out_illegal = slice_data[STAGES-1][0];

endmodule

// File: tb/tb_utype_exec_pipe.sv
// Directed and randomized checks of utype_exec_pipe against an in-order
// queue model built from the operation rules.
module tb_utype_exec_pipe;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STAGES = 3;
    localparam int unsigned TAGW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [TAGW-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_rd;
    logic            out_illegal;

    utype_exec_pipe #(
        .XLEN  (XLEN),
        .STAGES(STAGES),
        .TAGW  (TAGW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_pc      (in_pc),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     t;
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] rd;
        logic            ill;
    } ent_t;

    ent_t        q[$];
    int unsigned cyc     = 0;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          last_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] imm);
        logic [XLEN-1:0] u;
        u = imm - (imm % 4096);
        case (op)
            2'd0:    return u;
            2'd1:    return pc + u;
            2'd2:    return pc + 4;
            default: return '0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [1:0] op, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] imm, input logic [TAGW-1:0] rd);
        in_valid = v;
        in_op    = op;
        in_pc    = pc;
        in_imm   = imm;
        in_rd    = rd;
    endtask

    // One clock: compare at the falling edge, update the model, advance past the rising edge.
    task automatic cycle();
        bit   exp_ov;
        ent_t e;
        @(negedge clk);
        check("in_ready", in_ready, (q.size() < STAGES) || out_ready);
        exp_ov = (q.size() > 0) && (cyc - q[0].t >= STAGES);
        check("out_valid", out_valid, exp_ov);
        if (out_valid && exp_ov) begin
            check("out_result", out_result, q[0].res);
            check("out_rd", out_rd, q[0].rd);
            check("out_illegal", out_illegal, q[0].ill);
        end
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        last_acc = 1'b0;
        if (flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            e.t   = cyc;
            e.res = ref_result(in_op, in_pc, in_imm);
            e.rd  = in_rd;
            e.ill = (in_op == 2'd3);
            q.push_back(e);
            last_acc = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 2'd0, '0, '0, '0);
        repeat (n) cycle();
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_result"}, out_result, '0);
        check({tag, "_out_rd"}, out_rd, '0);
        check({tag, "_out_illegal"}, out_illegal, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    int unsigned idx;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, '0, '0, '0);
        repeat (2) begin @(posedge clk); cyc++; #1; end
        reset_check("rst");
        @(posedge clk); cyc++; #1;
        reset = 1'b0;

        // Single ops, then wrap-around cases.
        drive(1'b1, 2'd0, 32'h0, 32'h1234_5ABC, 5'd1);  cycle();
        drive(1'b1, 2'd1, 32'h1000, 32'h2000, 5'd2);    cycle();
        drive(1'b1, 2'd2, 32'h80, 32'hDEAD_BEEF, 5'd3); cycle();
        drive(1'b1, 2'd1, 32'hFFFF_F000, 32'h2000, 5'd4); cycle();
        drive(1'b1, 2'd2, 32'hFFFF_FFFC, 32'h0, 5'd5);  cycle();
        idle(STAGES + 2);

        // Illegal op followed by a legal one.
        drive(1'b1, 2'd3, 32'h1234, 32'hFFFF_FFFF, 5'd7); cycle();
        drive(1'b1, 2'd0, 32'h0, 32'hABCD_E123, 5'd8);    cycle();
        idle(STAGES + 2);

        // Backpressure: out_ready low for stream cycles 1..5.
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            if (idx < 6) drive(1'b1, 2'(idx % 3), 32'h100 * idx, 32'h1111_1000 * idx, 5'(10 + idx));
            else drive(1'b0, 2'd0, '0, '0, '0);
            out_ready = !(i >= 1 && i <= 5);
            cycle();
            if (last_acc) idx++;
        end
        check("bp_accepted", idx, 6);
        out_ready = 1'b1;
        idle(STAGES + 1);

        // Flush with a full pipeline and a same-cycle input.
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive(1'b1, 2'd2, 32'h400 + 32'(i), '0, 5'(20 + i));
            cycle();
        end
        drive(1'b1, 2'd0, '0, 32'h7777_7000, 5'd30);
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(STAGES + 2);

        // Reset with two entries in flight.
        drive(1'b1, 2'd2, 32'h10, '0, 5'd11); cycle();
        drive(1'b1, 2'd2, 32'h20, '0, 5'd12); cycle();
        drive(1'b0, 2'd0, '0, '0, '0);
        reset = 1'b1;
        @(posedge clk); cyc++; #1;
        reset_check("midrst");
        q.delete();
        @(posedge clk); cyc++; #1;
        reset = 1'b0;
        idle(STAGES + 1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            cycle();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(STAGES + 2);
        check("drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
